// File: rtl/rose_capture_delay_responder.sv
// rtl/rose_capture_delay_responder.sv - rise-captured payload delay line with bounded, in-order delivery
module rose_capture_delay_responder #(
  parameter int         DATA_W    = 10,
  parameter int         MIN_LAT   = 1,
  parameter int         MAX_LAT   = 3,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        lat_force,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic [2:0]        pending,
  output logic              overflow
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                USED_W   = PTR_W + 1;
  localparam logic [7:0]        LAT_SPAN = 8'(MAX_LAT - MIN_LAT + 1);
  localparam logic [2:0]        MIN_L    = 3'(MIN_LAT);
  localparam logic [2:0]        MAX_L    = 3'(MAX_LAT);
  localparam logic [USED_W-1:0] FULL     = USED_W'(DEPTH);

  logic              dv_q;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [DATA_W-1:0] payload_q [DEPTH];
  logic [DATA_W-1:0] payload_d [DEPTH];
  logic [2:0]        cnt_q [DEPTH];
  logic [2:0]        cnt_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [USED_W-1:0] used_q, used_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              dov_q, dov_d;
  logic              ovf_q, ovf_d;

  logic              capture;
  logic [2:0]        rand_lat;
  logic [2:0]        force_lat;
  logic [2:0]        lat_sel;

  // Galois-free Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every cycle
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Per-transfer latency: random from the current LFSR value, or forced and clamped into range
  always_comb begin
    rand_lat  = 3'(8'(MIN_LAT) + (lfsr_q % LAT_SPAN));
    force_lat = {1'b0, lat_force};
    if (force_lat < MIN_L) begin
      force_lat = MIN_L;
    end else if (force_lat > MAX_L) begin
      force_lat = MAX_L;
    end
    lat_sel = (lat_force == 2'd0) ? rand_lat : force_lat;
  end

  assign capture = data_valid & ~dv_q;

  // Edge update: age all entries, deliver an expiring head, then append any new capture
  always_comb begin
    logic              pop;
    logic [USED_W-1:0] used_after;
    logic [PTR_W-1:0]  newest_idx;
    logic [PTR_W-1:0]  tail_idx;
    logic [2:0]        t_plus1;
    logic [2:0]        push_cnt;

    payload_d  = payload_q;
    head_d     = head_q;
    used_d     = used_q;
    data_out_d = data_out_q;
    dov_d      = 1'b0;
    ovf_d      = ovf_q;

    // Free slots always hold count 0, so decrementing only nonzero counts ages exactly the live entries.
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = (cnt_q[i] != 3'd0) ? (cnt_q[i] - 3'd1) : 3'd0;
    end

    pop        = (used_q != '0) && (cnt_q[head_q] == 3'd1);
    used_after = pop ? (used_q - 1'b1) : used_q;
    if (pop) begin
      data_out_d = payload_q[head_q];
      dov_d      = 1'b1;
      head_d     = head_q + 1'b1;
    end

    // A new entry must expire strictly after the newest surviving one, which keeps delivery in order.
    newest_idx = head_q + PTR_W'(used_q - 1'b1);
    t_plus1    = (used_after != '0) ? (cnt_d[newest_idx] + 3'd1) : 3'd1;
    push_cnt   = (lat_sel > t_plus1) ? lat_sel : t_plus1;
    tail_idx   = head_q + PTR_W'(used_q);

    if (capture) begin
      if (used_after == FULL) begin
        ovf_d = 1'b1;
      end else begin
        payload_d[tail_idx] = data;
        cnt_d[tail_idx]     = push_cnt;
        used_after          = used_after + 1'b1;
      end
    end
    used_d = used_after;
  end

  // State registers; reset discards every pending entry at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dv_q       <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      head_q     <= '0;
      used_q     <= '0;
      data_out_q <= '0;
      dov_q      <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_q[i] <= '0;
        cnt_q[i]     <= 3'd0;
      end
    end else begin
      dv_q       <= data_valid;
      lfsr_q     <= lfsr_d;
      head_q     <= head_d;
      used_q     <= used_d;
      data_out_q <= data_out_d;
      dov_q      <= dov_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        payload_q[i] <= payload_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
    end
  end

  // Occupancy report, saturated to the 3-bit port
  always_comb begin
    pending = (32'(used_q) > 32'd7) ? 3'd7 : 3'(used_q);
  end

  assign data_out       = data_out_q;
  assign data_out_valid = dov_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_rose_capture_delay_responder.sv
// tb/tb_rose_capture_delay_responder.sv - directed self-checking bench for rose_capture_delay_responder
module tb_rose_capture_delay_responder;

  logic       clk;
  logic       reset;
  logic       data_valid;
  logic [9:0] data;
  logic [1:0] lat_force;
  logic [9:0] data_out;
  logic       data_out_valid;
  logic [2:0] pending;
  logic       overflow;

  logic       data_valid2;
  logic [9:0] data2;
  logic [1:0] lat_force2;
  logic [9:0] data_out2;
  logic       data_out_valid2;
  logic [2:0] pending2;
  logic       overflow2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0] exp_q[$];
  int         cap_q[$];
  logic [9:0] got2[$];
  int         pulses;

  rose_capture_delay_responder dut (
    .clk            (clk),
    .reset          (reset),
    .data_valid     (data_valid),
    .data           (data),
    .lat_force      (lat_force),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .pending        (pending),
    .overflow       (overflow)
  );

  rose_capture_delay_responder #(
    .MIN_LAT (7),
    .MAX_LAT (7),
    .DEPTH   (2)
  ) dut2 (
    .clk            (clk),
    .reset          (reset),
    .data_valid     (data_valid2),
    .data           (data2),
    .lat_force      (lat_force2),
    .data_out       (data_out2),
    .data_out_valid (data_out_valid2),
    .pending        (pending2),
    .overflow       (overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_delivery();
    int lat;
    if (data_out_valid) begin
      if (exp_q.size() == 0) begin
        check("rnd_spurious", 32'd1, 32'd0);
      end else begin
        lat = cyc - cap_q[0];
        check("rnd_data", 32'(data_out), 32'(exp_q[0]));
        check("rnd_latency_1to3", 32'((lat >= 1) && (lat <= 3)), 32'd1);
        void'(exp_q.pop_front());
        void'(cap_q.pop_front());
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    data_valid  = 1'b0;
    data        = '0;
    lat_force   = 2'd0;
    data_valid2 = 1'b0;
    data2       = '0;
    lat_force2  = 2'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_dov", 32'(data_out_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_overflow2", 32'(overflow2), 32'd0);

    // Fixed latency 2: capture at E, deliver after E+2
    lat_force  = 2'd2;
    data       = 10'd37;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("fix_pending_E", 32'(pending), 32'd1);
    check("fix_dov_E", 32'(data_out_valid), 32'd0);
    tick();
    check("fix_dov_E1", 32'(data_out_valid), 32'd0);
    tick();
    check("fix_data_E2", 32'(data_out), 32'd37);
    check("fix_dov_E2", 32'(data_out_valid), 32'd1);
    check("fix_pending_E2", 32'(pending), 32'd0);
    tick();
    check("fix_dov_E3", 32'(data_out_valid), 32'd0);
    check("fix_hold_E3", 32'(data_out), 32'd37);

    // In-order clamp: 5 at lat 3, then 9 at lat 1 two edges later
    lat_force  = 2'd3;
    data       = 10'd5;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    lat_force  = 2'd1;
    data       = 10'd9;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("ord_pending_E2", 32'(pending), 32'd2);
    check("ord_dov_E2", 32'(data_out_valid), 32'd0);
    tick();
    check("ord_data_E3", 32'(data_out), 32'd5);
    check("ord_dov_E3", 32'(data_out_valid), 32'd1);
    tick();
    check("ord_data_E4", 32'(data_out), 32'd9);
    check("ord_dov_E4", 32'(data_out_valid), 32'd1);
    tick();
    check("ord_dov_E5", 32'(data_out_valid), 32'd0);
    check("ord_pending_E5", 32'(pending), 32'd0);

    // Random latency: pulses two cycles apart, in-order delivery within 1..3 edges
    lat_force = 2'd0;
    repeat (2) tick();
    for (int n = 0; n < 2000; n++) begin
      data       = 10'($urandom_range(100, 0));
      data_valid = 1'b1;
      tick();
      check_delivery();
      exp_q.push_back(data);
      cap_q.push_back(cyc);
      data_valid = 1'b0;
      tick();
      check_delivery();
    end
    repeat (5) begin
      tick();
      check_delivery();
    end
    check("rnd_all_delivered", 32'(exp_q.size()), 32'd0);
    check("rnd_overflow", 32'(overflow), 32'd0);

    // Level vs rise: five cycles high yields exactly one delivery
    lat_force  = 2'd1;
    data       = 10'd77;
    data_valid = 1'b1;
    pulses     = 0;
    repeat (5) begin
      tick();
      if (data_out_valid) pulses++;
    end
    data_valid = 1'b0;
    repeat (4) begin
      tick();
      if (data_out_valid) pulses++;
    end
    check("lvl_pulses", 32'(pulses), 32'd1);
    check("lvl_data", 32'(data_out), 32'd77);
    check("lvl_pending", 32'(pending), 32'd0);

    // Overflow on the depth-2, latency-7 instance: third capture dropped
    data2       = 10'd11;
    data_valid2 = 1'b1;
    tick();
    data_valid2 = 1'b0;
    tick();
    data2       = 10'd22;
    data_valid2 = 1'b1;
    tick();
    data_valid2 = 1'b0;
    check("ovf_not_yet", 32'(overflow2), 32'd0);
    tick();
    data2       = 10'd33;
    data_valid2 = 1'b1;
    tick();
    data_valid2 = 1'b0;
    check("ovf_set", 32'(overflow2), 32'd1);
    check("ovf_pending", 32'(pending2), 32'd2);
    repeat (12) begin
      tick();
      if (data_out_valid2) got2.push_back(data_out2);
    end
    check("ovf_deliveries", 32'(got2.size()), 32'd2);
    if (got2.size() == 2) begin
      check("ovf_first", 32'(got2[0]), 32'd11);
      check("ovf_second", 32'(got2[1]), 32'd22);
    end
    check("ovf_sticky", 32'(overflow2), 32'd1);

    // Reset mid-flight: entry discarded, no later delivery
    lat_force  = 2'd3;
    data       = 10'd64;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    check("rmf_pending_before", 32'(pending), 32'd1);
    check("rmf_data_before", 32'(data_out), 32'd77);
    reset = 1'b1;
    #1;
    check("rmf_pending_async", 32'(pending), 32'd0);
    check("rmf_data_async", 32'(data_out), 32'd0);
    check("rmf_ovf2_cleared", 32'(overflow2), 32'd0);
    tick();
    tick();
    reset  = 1'b0;
    pulses = 0;
    repeat (6) begin
      tick();
      if (data_out_valid) pulses++;
    end
    check("rmf_no_delivery", 32'(pulses), 32'd0);
    check("rmf_data_after", 32'(data_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
